// File: rtl/mosaic_gen.sv
// Reads three 8-bit colour planes in raster order and emits a single-channel Bayer mosaic stream.
// A 2-entry output buffer absorbs sink back-pressure; reads are throttled so it never overflows.
module mosaic_gen #(
    parameter int WIDTH   = 128,
    parameter int HEIGHT  = 128,
    parameter int AW      = 14,
    parameter int PATTERN = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic [AW-1:0] addr_r,
    output logic [AW-1:0] addr_g,
    output logic [AW-1:0] addr_b,
    input  logic [7:0]    rdata_r,
    input  logic [7:0]    rdata_g,
    input  logic [7:0]    rdata_b,
    output logic          out_en,
    input  logic          out_ready,
    output logic [7:0]    data_out,
    output logic          busy,
    output logic          done
);

    localparam int            NPIX     = WIDTH * HEIGHT;
    localparam logic [AW-1:0] LAST_PIX = AW'(NPIX - 1);
    localparam logic [AW-1:0] LAST_COL = AW'(WIDTH - 1);
    localparam logic [1:0]    PL_R     = 2'd0;
    localparam logic [1:0]    PL_G     = 2'd1;
    localparam logic [1:0]    PL_B     = 2'd2;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] ptr;
    logic [AW-1:0] col;
    logic          row_odd;
    logic          issue, push, pop;
    logic [2:0]    room;
    logic          vld_p0;
    logic [1:0]    sel_p0;
    logic [7:0]    din_p1;
    logic [7:0]    head, tail;
    logic [1:0]    occ;

    // CFA plane for a pixel given the parity of its row and column
    function automatic logic [1:0] plane_sel(input logic row_b, input logic col_b);
        logic [1:0] pl;
        pl = PL_G;
        case (PATTERN)
            1: case ({row_b, col_b})
                   2'b00:   pl = PL_R;
                   2'b11:   pl = PL_B;
                   default: pl = PL_G;
               endcase
            2: case ({row_b, col_b})
                   2'b00:   pl = PL_B;
                   2'b11:   pl = PL_R;
                   default: pl = PL_G;
               endcase
            3: case ({row_b, col_b})
                   2'b01:   pl = PL_B;
                   2'b10:   pl = PL_R;
                   default: pl = PL_G;
               endcase
            default: case ({row_b, col_b})
                   2'b01:   pl = PL_R;
                   2'b10:   pl = PL_B;
                   default: pl = PL_G;
               endcase
        endcase
        return pl;
    endfunction

    function automatic logic [7:0] plane_pick(input logic [1:0] sel, input logic [7:0] r,
                                              input logic [7:0] g, input logic [7:0] b);
        logic [7:0] v;
        v = g;
        if (sel == PL_R) v = r;
        else if (sel == PL_B) v = b;
        return v;
    endfunction

    assign addr_r   = ptr;
    assign addr_g   = ptr;
    assign addr_b   = ptr;
    assign out_en   = (occ != 2'd0);
    assign data_out = head;
    assign pop      = out_en && out_ready;
    assign push     = vld_p0;
    // Slots still owed after this cycle: buffered + arriving - departing
    assign room     = 3'(occ) + 3'(vld_p0) - 3'(pop);
    assign issue    = (state == RUN) && (room <= 3'd1);

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE:  if (start) state_nxt = RUN;
            RUN: begin
                busy = 1'b1;
                if (issue && ptr == LAST_PIX) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (occ == 2'd1 && !vld_p0 && pop) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            ptr     <= '0;
            col     <= '0;
            row_odd <= 1'b0;
            vld_p0  <= 1'b0;
            occ     <= 2'd0;
            head    <= 8'h00;
        end else begin
            state  <= state_nxt;
            vld_p0 <= issue;
            if (issue) begin
                if (ptr == LAST_PIX) begin
                    ptr     <= '0;
                    col     <= '0;
                    row_odd <= 1'b0;
                end else begin
                    ptr <= ptr + 1'b1;
                    if (col == LAST_COL) begin
                        col     <= '0;
                        row_odd <= ~row_odd;
                    end else begin
                        col <= col + 1'b1;
                    end
                end
            end
            occ <= 2'(3'(occ) + 3'(push) - 3'(pop));
            case ({push, pop})
                2'b10:   if (occ == 2'd0) head <= din_p1;
                2'b01:   head <= tail;
                2'b11:   head <= (occ == 2'd2) ? tail : din_p1;
                default: head <= head;
            endcase
        end
    end

    // p0: select travels with the read; p1: selected plane data enters the buffer
    always_ff @(posedge clk) begin
        sel_p0 <= plane_sel(row_odd, col[0]);
        if (push && ((occ == 2'd1 && !pop) || (occ == 2'd2 && pop)))
            tail <= din_p1;
    end

    assign din_p1 = plane_pick(sel_p0, rdata_r, rdata_g, rdata_b);

endmodule
